// File: rtl/sha3_scan_driver.sv
// Host-side job controller for the SHA3 nonce scanner: register loader, job sequencer and result streamer.
// Optional cycle counter for RUN+DRAIN enabled by defining SHA3_SCAN_DRIVER_PERF_EN.
module sha3_scan_driver (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              scn_start,
  output logic [23:0][31:0] scn_blobby,
  output logic [63:0]       scn_threshold,
  input  logic              scn_dispatching,
  input  logic              scn_evaluating,
  input  logic              scn_found,
  input  logic              scn_ready,
  input  logic [31:0]       scn_nonce,
`ifdef SHA3_SCAN_DRIVER_PERF_EN
  output logic [31:0]       perf_cycles,
`endif
  input  logic [49:0][31:0] scn_hash
);

`ifdef SHA3_SCAN_DRIVER_PERF_EN
  localparam int RESULT_WORDS = 53;
`else
  localparam int RESULT_WORDS = 52;
`endif
  localparam logic [5:0] LAST_IDX = 6'(RESULT_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_COLLECT = 3'd5,
    ST_READOUT = 3'd6
  } state_e;

  state_e             state_q;
  logic               wr_ready_q;
  logic               busy_q;
  logic               rd_valid_q;
  logic               rd_last_q;
  logic [31:0]        rd_data_q;
  logic               done_q;
  logic               hit_q;
  logic               scn_start_q;
  logic [23:0][31:0]  blobby_q;
  logic [63:0]        thr_q;
  logic               found_q;
  logic [31:0]        nonce_q;
  logic [49:0][31:0]  hash_q;
  logic [5:0]         idx_q;
  logic [5:0]         idx_d;
  logic [31:0]        word_d;
  logic [31:0]        perf_q;
  logic               unused_eval_s;

  assign unused_eval_s = scn_evaluating;

  // Result word that follows the one currently presented on rd_data.
  always_comb begin
    idx_d  = idx_q + 6'd1;
    word_d = 32'd0;
    if (idx_d == 6'd1) begin
      word_d = nonce_q;
    end else if ((idx_d >= 6'd2) && (idx_d <= 6'd51)) begin
      word_d = hash_q[idx_d - 6'd2];
    end else if (idx_d == 6'd52) begin
      word_d = perf_q;
    end else begin
      word_d = {31'd0, found_q};
    end
  end

  // Job sequencer, host register file, scanner handshake and result stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= 32'd0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      scn_start_q <= 1'b0;
      blobby_q    <= '0;
      thr_q       <= 64'd0;
      found_q     <= 1'b0;
      nonce_q     <= 32'd0;
      hash_q      <= '0;
      idx_q       <= 6'd0;
      perf_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_valid && wr_ready_q) begin
            case (wr_addr)
              5'd24: thr_q[31:0]  <= wr_data;
              5'd25: thr_q[63:32] <= wr_data;
              5'd26: begin
                state_q     <= ST_START;
                scn_start_q <= 1'b1;
                busy_q      <= 1'b1;
                wr_ready_q  <= 1'b0;
                done_q      <= 1'b0;
                hit_q       <= 1'b0;
                perf_q      <= 32'd0;
              end
              default: begin
                if (wr_addr < 5'd24) begin
                  blobby_q[wr_addr] <= wr_data;
                end
              end
            endcase
          end
        end
        ST_START: begin
          if (scn_ready) begin
            state_q     <= ST_LAUNCH;
            scn_start_q <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          if (scn_dispatching) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!scn_dispatching) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (scn_ready) begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // Word 0 is taken straight from the scanner since the snapshot lands on this same edge.
          found_q    <= scn_found;
          nonce_q    <= scn_nonce;
          hash_q     <= scn_hash;
          hit_q      <= scn_found;
          idx_q      <= 6'd0;
          rd_valid_q <= 1'b1;
          rd_data_q  <= {31'd0, scn_found};
          rd_last_q  <= 1'b0;
          state_q    <= ST_READOUT;
        end
        ST_READOUT: begin
          if (rd_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q    <= ST_IDLE;
              rd_valid_q <= 1'b0;
              rd_data_q  <= 32'd0;
              rd_last_q  <= 1'b0;
              busy_q     <= 1'b0;
              wr_ready_q <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              rd_data_q <= word_d;
              rd_last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          wr_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
          rd_data_q   <= 32'd0;
          scn_start_q <= 1'b0;
        end
      endcase
`ifdef SHA3_SCAN_DRIVER_PERF_EN
      if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (perf_q != 32'hFFFF_FFFF)) begin
        perf_q <= perf_q + 32'd1;
      end
`endif
    end
  end

  assign wr_ready      = wr_ready_q;
  assign busy          = busy_q;
  assign rd_valid      = rd_valid_q;
  assign rd_last       = rd_last_q;
  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign hit           = hit_q;
  assign scn_start     = scn_start_q;
  assign scn_blobby    = blobby_q;
  assign scn_threshold = thr_q;
`ifdef SHA3_SCAN_DRIVER_PERF_EN
  assign perf_cycles   = perf_q;
`endif

endmodule

// File: tb/tb_sha3_scan_driver.sv
// Directed bench for sha3_scan_driver: bench-side scanner model plus a stream model checked every cycle.
module tb_sha3_scan_driver;

`ifdef SHA3_SCAN_DRIVER_PERF_EN
  localparam int NW = 53;
`else
  localparam int NW = 52;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              hit;
  logic              scn_start;
  logic [23:0][31:0] scn_blobby;
  logic [63:0]       scn_threshold;
  logic              scn_dispatching;
  logic              scn_evaluating;
  logic              scn_found;
  logic              scn_ready;
  logic [31:0]       scn_nonce;
  logic [49:0][31:0] scn_hash;
`ifdef SHA3_SCAN_DRIVER_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  always #5 clk = ~clk;

  sha3_scan_driver dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .hit(hit), .scn_start(scn_start),
    .scn_blobby(scn_blobby), .scn_threshold(scn_threshold),
    .scn_dispatching(scn_dispatching), .scn_evaluating(scn_evaluating),
    .scn_found(scn_found), .scn_ready(scn_ready), .scn_nonce(scn_nonce),
`ifdef SHA3_SCAN_DRIVER_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .scn_hash(scn_hash)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_words [0:52];
  logic [31:0] got_words [0:52];
  int          rd_idx = 0;
  int          rd_cycles = 0;
  bit          toggle_mode = 1'b0;
  bit          tog_phase = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] dat);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = dat;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Stream checker and host reader: runs every cycle, drives rd_ready.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (prev_stall) chk("stall_hold", 64'(rd_data), 64'(prev_data));
        if (rd_idx < NW) begin
          chk("rd_data", 64'(rd_data), 64'(exp_words[rd_idx]));
          chk("rd_last", 64'(rd_last), 64'(rd_idx == NW - 1));
          got_words[rd_idx] = rd_data;
        end else begin
          chk("rd_overrun", 64'(rd_idx), 64'(NW - 1));
        end
        rd_cycles++;
        if (toggle_mode) begin
          rd_ready  = tog_phase;
          tog_phase = ~tog_phase;
        end else begin
          rd_ready = 1'b1;
        end
        prev_stall = !rd_ready;
        prev_data  = rd_data;
        if (rd_ready) rd_idx++;
      end else begin
        chk("rd_data_idle", 64'(rd_data), 64'd0);
        chk("rd_last_idle", 64'(rd_last), 64'd0);
        rd_ready   = !toggle_mode;
        prev_stall = 1'b0;
      end
    end
  end

  // One job: GO, scanner handshake (d cycles dispatching, w cycles draining), then result readout.
  task automatic run_job(input bit f, input logic [31:0] nonce, input logic [31:0] base,
                         input int d, input int w, input bit tog, input bit run_wr, input bit drain_rst);
    logic [31:0] blob5;
    int t;
    exp_words[0] = {31'd0, f};
    exp_words[1] = nonce;
    for (int k = 0; k < 50; k++) exp_words[k + 2] = base + 32'(k);
    exp_words[52] = 32'(d + w);
    rd_idx = 0; rd_cycles = 0; toggle_mode = tog; tog_phase = 1'b0; prev_stall = 1'b0;
    blob5 = scn_blobby[5];
    write_reg(5'd26, 32'hDEAD_BEEF);
    chk("go_start", 64'(scn_start), 64'd1);
    chk("go_busy", 64'(busy), 64'd1);
    chk("go_wr_ready", 64'(wr_ready), 64'd0);
    chk("go_done_clr", 64'(done), 64'd0);
    chk("go_hit_clr", 64'(hit), 64'd0);
    @(negedge clk);
    chk("launch_start_low", 64'(scn_start), 64'd0);
    scn_ready = 1'b0;
    scn_dispatching = 1'b1;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (run_wr && i == 0) begin
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        chk("run_wr_ready", 64'(wr_ready), 64'd0);
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    scn_dispatching = 1'b0;
    scn_found = f;
    scn_nonce = nonce;
    for (int k = 0; k < 50; k++) scn_hash[k] = base + 32'(k);
    if (run_wr) chk("run_wr_blob5", 64'(scn_blobby[5]), 64'(blob5));
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (drain_rst && i == 1) begin
        chk("drain_busy_pre", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("drain_rst_busy", 64'(busy), 64'd0);
        chk("drain_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("drain_rst_start", 64'(scn_start), 64'd0);
        chk("drain_rst_rd_valid", 64'(rd_valid), 64'd0);
        rst = 1'b1;
        scn_ready = 1'b1;
        return;
      end
    end
    scn_ready = 1'b1;
    t = 0;
    while (!done && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("job_done", 64'(done), 64'd1);
    chk("readout_cycles", 64'(rd_cycles), tog ? 64'(2 * NW) : 64'(NW));
    chk("words_taken", 64'(rd_idx), 64'(NW));
    chk("job_hit", 64'(hit), 64'(f));
    chk("job_busy_end", 64'(busy), 64'd0);
    chk("job_wr_ready_end", 64'(wr_ready), 64'd1);
  endtask

  logic [23:0][31:0] exp_blob;

  initial begin
    rst = 1'b0; wr_valid = 1'b1; wr_addr = 5'd26; wr_data = 32'hFFFF_FFFF;
    scn_ready = 1'b1; scn_dispatching = 1'b0; scn_evaluating = 1'b0;
    scn_found = 1'b0; scn_nonce = 32'd0; scn_hash = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_start", 64'(scn_start), 64'd0);
    chk("rst_blobby", 64'(scn_blobby == '0), 64'd1);
    chk("rst_thr", scn_threshold, 64'd0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_blobby", 64'(scn_blobby == '0), 64'd1);

    for (int n = 0; n < 24; n++) begin
      write_reg(5'(n), 32'(n));
      exp_blob[n] = 32'(n);
    end
    write_reg(5'd24, 32'hFFFF_FFFF);
    write_reg(5'd25, 32'hFFFF_FFFF);
    for (int n = 0; n < 24; n++) chk("load_blobby", 64'(scn_blobby[n]), 64'(n));
    chk("load_thr", scn_threshold, 64'hFFFF_FFFF_FFFF_FFFF);
    write_reg(5'd30, 32'h5555_AAAA);
    chk("addr30_blobby", 64'(scn_blobby == exp_blob), 64'd1);
    chk("addr30_thr", scn_threshold, 64'hFFFF_FFFF_FFFF_FFFF);

    run_job(1'b1, 32'h0000_0000, 32'hA500_0000, 4, 3, 1'b0, 1'b1, 1'b0);
    chk("j1_word0", 64'(got_words[0]), 64'd1);
    chk("j1_word51", 64'(got_words[51]), 64'hA500_0031);
    chk("j1_blob5", 64'(scn_blobby[5]), 64'd5);

    write_reg(5'd24, 32'd0);
    write_reg(5'd25, 32'd0);
    chk("thr_zero", scn_threshold, 64'd0);
    run_job(1'b0, 32'hFFFF_FFFF, 32'h3C00_0000, 3, 2, 1'b0, 1'b0, 1'b0);
    chk("j2_word0", 64'(got_words[0]), 64'd0);
    chk("j2_word2", 64'(got_words[2]), 64'h3C00_0000);

    run_job(1'b1, 32'h1234_5678, 32'h5A5A_0000, 2, 4, 1'b1, 1'b0, 1'b0);
    chk("j3_word1", 64'(got_words[1]), 64'h1234_5678);
    chk("j3_word27", 64'(got_words[27]), 64'h5A5A_0019);

    run_job(1'b1, 32'h0BAD_0BAD, 32'h1100_0000, 2, 4, 1'b0, 1'b0, 1'b1);
    chk("rst_job_blobby", 64'(scn_blobby == '0), 64'd1);
    run_job(1'b1, 32'hCAFE_F00D, 32'h7700_0000, 2, 2, 1'b0, 1'b0, 1'b0);
    chk("j5_word1", 64'(got_words[1]), 64'hCAFE_F00D);
    chk("j5_word51", 64'(got_words[51]), 64'h7700_0031);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
